mips_operand_stage: RTL and testbench
=====================================

# mips_operand_stage

Operand-fetch stage directly upstream of the MIPS ALU. Accepts a 32-bit instruction per valid/ready handshake, reads rs/rt from a 32×32 register file, and builds the ALU operands, including immediate extension. It presents a registered instruction/operand bundle to the ALU and takes the ALU result back through a writeback port. A busy-register scoreboard stalls issue on read-after-write hazards.

## Interface
- `NREG`, default 32: register count; fixed, index width 5.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction offered.
- `in_ins`  in  32  MIPS instruction word.
- `in_ready`  out  1  stage accepts `in_ins` this cycle.
- `out_valid`  out  1  operand bundle valid.
- `out_ready`  in  1  ALU side consumes the bundle.
- `out_ins`  out  32  instruction for the ALU, with bits [25:21] forced to 5'b00000.
- `out_regA`  out  32  rs operand.
- `out_regB`  out  32  rt operand or extended immediate.
- `out_dest`  out  5  destination register; 0 means none.
- `wb_en`  in  1  writeback strobe.
- `wb_addr`  in  5  writeback register.
- `wb_data`  in  32  writeback value.
- `illegal`  out  1  one-cycle pulse when an unsupported instruction is accepted.

## Operation
- **Supported instructions:**
  - R-type (opcode 0), funct ∈ {0, 2, 3, 4, 6, 7, 32–39, 42, 43}.
  - Opcodes 4, 5, 8–14, 35, 43.
  - Anything else is illegal: accepted, dropped, `illegal`=1 for one cycle, no bundle produced.
- **Source registers:**
  - rs = ins[25:21]; rt = ins[20:16].
  - The shifts sll/srl/sra read rt only.
- **regA** = RF[rs].
- **regB:**
  - R-type, beq, bne: RF[rt].
  - addi, addiu, slti, sltiu, lw, sw: sign-extended ins[15:0].
  - andi, ori, xori: zero-extended ins[15:0].
- **out_ins:** in_ins with [25:21] replaced by 0, which selects regA as the ALU's rs operand. All other bits are unchanged, so shamt and funct pass through.
- **dest:**
  - R-type: ins[15:11].
  - Opcodes 8–14 and 35: ins[20:16].
  - sw, beq, bne: 0.
- **RF:**
  - RF[0] always reads 0; writes to 0 are ignored.
  - Write happens on a clock edge when `wb_en`=1.
  - Same-cycle read of `wb_addr` (≠0) returns `wb_data` (bypass).
- **Scoreboard:** 32-bit busy vector; bit 0 is always 0.
  - Issuing an instruction with dest≠0 sets busy[dest].
  - `wb_en` clears busy[wb_addr].
  - If the set and the clear hit the same register in the same cycle, set wins.
- **Hazard:** a read source r≠0 with busy[r]=1 is a hazard, unless `wb_en` and `wb_addr`=r this cycle; in that case the source is bypassed and there is no stall.
- **in_ready** = !rst && (!out_valid || out_ready) && !hazard.
  - An illegal instruction is never held for a hazard.
- **Reset:**
  - Outputs: out_valid=0, out_ins=0, out_regA=0, out_regB=0, out_dest=0, illegal=0.
  - All RF entries = 0; busy = 0.
  - Any in-flight bundle is discarded.

## Timing
- **Latency:** 1 cycle. Accept at edge N, bundle valid after edge N; throughput 1/cycle with no hazard.
- **Bundle hold:** the bundle stays stable while out_valid && !out_ready.
- **Transfer:** occurs on the edge where out_valid && out_ready. The bundle is replaced on that same edge if in_valid && in_ready, otherwise out_valid falls.
- **Stall cost:** a dependent instruction waits until the cycle its source's writeback is presented. Back-to-back dependence costs exactly the ALU round-trip.
- **illegal:** registered; high for the cycle after the accepting edge.
- **Reset:** rst takes priority over every other event at an edge.

## Structure
- **Package `mips_pkg`:**
  - opcode constants (RTYPE=0, BEQ=4, BNE=5, ADDI=8 … XORI=14, LW=35, SW=43);
  - funct constants (SLL=0 … SLTU=43);
  - extension-kind enum {EXT_NONE, EXT_SIGN, EXT_ZERO}.
- **Sub-module `mips_regfile`:** 2 read ports, 1 write port, write-to-read bypass, RF[0]=0, synchronous reset clearing.
- **Remainder of the top level:** decode, scoreboard, and the output pipeline register.

## Test plan
- **Reset, then single add:** reset, wb 5←7, wb 6←9, then issue `add $3,$5,$6` (0x00A61820).
  - Required: out_regA=7, out_regB=9, out_dest=3, out_ins[25:21]=0, out_valid one cycle after accept.
- **Immediate extension:**
  - addi imm 0xFFFF → out_regB=0xFFFFFFFF.
  - ori imm 0xFFFF → out_regB=0x0000FFFF.
  - sw → out_dest=0.
- **RAW stall:**
  - Issue `add $3,…`, then `sub $4,$3,$5` → in_ready=0 until wb 3←0x10.
  - In the wb cycle: accepted, out_regA=0x10.
- **Backpressure:** out_ready=0 for 3 cycles with in_valid=1.
  - Required: the bundle is held unchanged, in_ready=0, and no instruction is lost or duplicated after release.
- **$0 and illegal opcode:**
  - wb 0←0xDEAD, then read $0 → 0.
  - Opcode 0x3F → illegal pulse, no out_valid.
- **Reset mid-stall:** assert rst while stalled.
  - Required: out_valid=0 and busy cleared next cycle; a dependent instruction then issues immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and operand-extension kinds for the MIPS
// operand-fetch stage.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SRA  = 6'd3;
  localparam logic [5:0] FN_SLLV = 6'd4;
  localparam logic [5:0] FN_SRLV = 6'd6;
  localparam logic [5:0] FN_SRAV = 6'd7;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SLTU = 6'd43;

  typedef enum logic [1:0] {
    EXT_NONE,
    EXT_SIGN,
    EXT_ZERO
  } ext_kind_t;

  function automatic logic funct_supported(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT, FN_SLTU: funct_supported = 1'b1;
      default:                          funct_supported = 1'b0;
    endcase
  endfunction

  // Constant-shift forms take their operand from rt only.
  function automatic logic funct_is_shamt(input logic [5:0] fn);
    funct_is_shamt = (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// write-to-read bypass, $0 hardwired to zero, synchronous reset clear.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RAW-1:0]  raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [RAW-1:0]  raddr_b,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [RAW-1:0]  waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
    if (we && (waddr == raddr_a)) rdata_a = wdata;
    if (we && (waddr == raddr_b)) rdata_b = wdata;
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/mips_operand_stage.sv
// Operand-fetch stage ahead of the MIPS ALU: decode, register read with
// immediate extension, busy-register scoreboard and registered output bundle.
module mips_operand_stage
  import mips_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_ins,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ins,
  output logic [31:0]     out_regA,
  output logic [31:0]     out_regB,
  output logic [4:0]      out_dest,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            illegal
);

  // Handshake: a word moves across a port on a rising edge where its valid
  // and ready are both high; valid, once raised, holds its payload stable
  // until that edge, and ready may depend combinationally on this cycle's state.

  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  logic            legal, use_rs, use_rt;
  ext_kind_t       ext;
  logic [4:0]      dest;
  logic [31:0]     rdata_a, rdata_b, regb;
  logic [NREG-1:0] busy, busy_next;
  logic            hazard, haz_rs, haz_rt, accept;

  assign opcode = in_ins[31:26];
  assign rs     = in_ins[25:21];
  assign rt     = in_ins[20:16];
  assign rd     = in_ins[15:11];
  assign imm    = in_ins[15:0];
  assign funct  = in_ins[5:0];

  mips_regfile #(.NREG(NREG)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .rdata_a (rdata_a),
    .raddr_b (rt),
    .rdata_b (rdata_b),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  always_comb begin
    legal  = 1'b0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    ext    = EXT_NONE;
    dest   = 5'd0;
    case (opcode)
      OP_RTYPE: begin
        if (funct_supported(funct)) begin
          legal  = 1'b1;
          use_rs = !funct_is_shamt(funct);
          use_rt = 1'b1;
          dest   = rd;
        end
      end
      OP_BEQ, OP_BNE: begin
        legal  = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        legal  = 1'b1;
        use_rs = 1'b1;
        ext    = EXT_SIGN;
        dest   = rt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        legal  = 1'b1;
        use_rs = 1'b1;
        ext    = EXT_ZERO;
        dest   = rt;
      end
      OP_SW: begin
        legal  = 1'b1;
        use_rs = 1'b1;
        ext    = EXT_SIGN;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ext)
      EXT_SIGN: regb = {{16{imm[15]}}, imm};
      EXT_ZERO: regb = {16'h0000, imm};
      default:  regb = rdata_b;
    endcase
  end

  // A source whose writeback is presented this cycle is bypassed, not stalled.
  assign haz_rs = use_rs && (rs != 5'd0) && busy[rs] && !(wb_en && (wb_addr == rs));
  assign haz_rt = use_rt && (rt != 5'd0) && busy[rt] && !(wb_en && (wb_addr == rt));
  assign hazard = legal && (haz_rs || haz_rt);

  assign in_ready = !rst && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    busy_next = busy;
    if (wb_en) busy_next[wb_addr] = 1'b0;
    if (accept && legal && (dest != 5'd0)) busy_next[dest] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      out_valid <= 1'b0;
      out_ins   <= '0;
      out_regA  <= '0;
      out_regB  <= '0;
      out_dest  <= '0;
      illegal   <= 1'b0;
    end else begin
      busy    <= busy_next;
      illegal <= accept && !legal;
      if (accept && legal) begin
        out_valid <= 1'b1;
        out_ins   <= {in_ins[31:26], 5'b00000, in_ins[20:0]};
        out_regA  <= rdata_a;
        out_regB  <= regb;
        out_dest  <= dest;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_operand_stage.sv
// Directed bench for mips_operand_stage: reset, add, immediates, RAW stall,
// backpressure, $0 / illegal handling and reset while stalled.
module tb_mips_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_ins;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_regA;
  logic [31:0] out_regB;
  logic [4:0]  out_dest;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_ADD3  = 32'h00A61820; // add  $3,$5,$6
  localparam logic [31:0] I_ADDI  = 32'h20A7FFFF; // addi $7,$5,-1
  localparam logic [31:0] I_ORI   = 32'h34A8FFFF; // ori  $8,$5,0xffff
  localparam logic [31:0] I_SW    = 32'hACA60004; // sw   $6,4($5)
  localparam logic [31:0] I_SUB   = 32'h00652022; // sub  $4,$3,$5
  localparam logic [31:0] I_ADD9  = 32'h00004820; // add  $9,$0,$0
  localparam logic [31:0] I_ADD10 = 32'h00805020; // add  $10,$4,$0
  localparam logic [31:0] I_BAD   = 32'hFC000000; // opcode 0x3f

  always #5 clk = ~clk;

  mips_operand_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ins    (in_ins),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ins   (out_ins),
    .out_regA  (out_regA),
    .out_regB  (out_regB),
    .out_dest  (out_dest),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ins = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_ins", out_ins, 32'd0);
    chk("rst_out_regA", out_regA, 32'd0);
    chk("rst_out_regB", out_regB, 32'd0);
    chk("rst_out_dest", {27'd0, out_dest}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // single add
    wb(5'd5, 32'd7);
    wb(5'd6, 32'd9);
    in_valid = 1'b1; in_ins = I_ADD3;
    #1;
    chk("add_in_ready", {31'd0, in_ready}, 32'd1);
    chk("add_pre_valid", {31'd0, out_valid}, 32'd0);
    step();
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_regA", out_regA, 32'd7);
    chk("add_regB", out_regB, 32'd9);
    chk("add_dest", {27'd0, out_dest}, 32'd3);
    chk("add_ins", out_ins, 32'h00061820);
    step();
    chk("add_drained", {31'd0, out_valid}, 32'd0);

    // immediates, back to back
    in_valid = 1'b1; in_ins = I_ADDI;
    step();
    chk("addi_regB", out_regB, 32'hFFFFFFFF);
    chk("addi_dest", {27'd0, out_dest}, 32'd7);
    chk("addi_ins", out_ins, 32'h2007FFFF);
    in_ins = I_ORI;
    step();
    chk("ori_regB", out_regB, 32'h0000FFFF);
    chk("ori_regA", out_regA, 32'd7);
    chk("ori_dest", {27'd0, out_dest}, 32'd8);
    in_ins = I_SW;
    step();
    chk("sw_dest", {27'd0, out_dest}, 32'd0);
    chk("sw_regB", out_regB, 32'd4);
    chk("sw_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("sw_drained", {31'd0, out_valid}, 32'd0);

    // RAW stall on $3 (busy since the add)
    in_valid = 1'b1; in_ins = I_SUB;
    #1;
    chk("raw_stall0", {31'd0, in_ready}, 32'd0);
    step();
    chk("raw_stall1", {31'd0, in_ready}, 32'd0);
    chk("raw_no_valid", {31'd0, out_valid}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h10;
    #1;
    chk("raw_wb_ready", {31'd0, in_ready}, 32'd1);
    step();
    wb_en = 1'b0;
    chk("raw_valid", {31'd0, out_valid}, 32'd1);
    chk("raw_regA", out_regA, 32'h10);
    chk("raw_regB", out_regB, 32'd7);
    chk("raw_dest", {27'd0, out_dest}, 32'd4);
    chk("raw_ins", out_ins, 32'h00052022);

    // backpressure with sub bundle held, addi waiting
    out_ready = 1'b0; in_ins = I_ADDI;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("bp_hold_ins", out_ins, 32'h00052022);
      chk("bp_hold_regA", out_regA, 32'h10);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_next_ins", out_ins, 32'h2007FFFF);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // $0 stays zero
    wb(5'd0, 32'hDEAD);
    in_valid = 1'b1; in_ins = I_ADD9;
    step();
    in_valid = 1'b0;
    chk("r0_regA", out_regA, 32'd0);
    chk("r0_regB", out_regB, 32'd0);
    chk("r0_dest", {27'd0, out_dest}, 32'd9);
    step();

    // illegal opcode
    in_valid = 1'b1; in_ins = I_BAD;
    #1;
    chk("ill_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_no_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("ill_pulse_end", {31'd0, illegal}, 32'd0);

    // reset while stalled on $4 (busy since the sub)
    in_valid = 1'b1; in_ins = I_ADD10;
    #1;
    chk("rs_stalled", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("rs_issue_valid", {31'd0, out_valid}, 32'd1);
    chk("rs_issue_regA", out_regA, 32'd0);
    chk("rs_issue_dest", {27'd0, out_dest}, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
